// File: rtl/check_slider.sv
// Sliding-piece move checker (rook/bishop/queen by MODE). Walks the path one
// square per cycle and returns a registered verdict, a reason code and a done pulse.
module check_slider #(
  parameter int BOARD_N = 8,
  parameter int COORD_W = 3,
  parameter int PIECE_W = 4,
  parameter int MODE    = 2
) (
  input  logic                                          CLOCK_50,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [COORD_W-1:0]                            old_x,
  input  logic [COORD_W-1:0]                            old_y,
  input  logic [COORD_W-1:0]                            new_x,
  input  logic [COORD_W-1:0]                            new_y,
  input  logic [BOARD_N-1:0][BOARD_N-1:0][PIECE_W-1:0]  board_in,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          move_valid,
  output logic [1:0]                                    fail_code
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WALK, S_DONE} state_t;

  localparam int SW = COORD_W + 1;
  localparam logic [1:0] C_OK = 2'd0, C_GEOM = 2'd1, C_BLOCK = 2'd2, C_OWN = 2'd3;

  state_t state_q, state_d;
  logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d, nx_q, nx_d, ny_q, ny_d;
  logic signed [SW-1:0] cx_q, cx_d, cy_q, cy_d, sx_q, sx_d, sy_q, sy_d;
  logic src_col_q, src_col_d;
  logic valid_q, valid_d;
  logic [1:0] code_q, code_d;

  logic signed [SW-1:0] dx, dy, adx, ady;
  logic [PIECE_W-1:0] src_cell, cur_cell;
  logic ortho, diag, legal, at_dst;

  function automatic logic signed [SW-1:0] sgn(input logic signed [SW-1:0] v);
    if (v == '0)     return '0;
    else if (v[SW-1]) return '1;
    else             return {{(SW-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    dx       = $signed({1'b0, nx_q}) - $signed({1'b0, ox_q});
    dy       = $signed({1'b0, ny_q}) - $signed({1'b0, oy_q});
    adx      = dx[SW-1] ? -dx : dx;
    ady      = dy[SW-1] ? -dy : dy;
    ortho    = (dx != '0) ^ (dy != '0);
    diag     = (adx == ady) && (dx != '0);
    if (MODE == 0)      legal = ortho;
    else if (MODE == 1) legal = diag;
    else                legal = ortho | diag;
    src_cell = board_in[oy_q][ox_q];
    cur_cell = board_in[cy_q[COORD_W-1:0]][cx_q[COORD_W-1:0]];
    at_dst   = (cx_q == {1'b0, nx_q}) && (cy_q == {1'b0, ny_q});
  end

  always_comb begin
    state_d   = state_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    nx_d      = nx_q;
    ny_d      = ny_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    src_col_d = src_col_q;
    valid_d   = valid_q;
    code_d    = code_q;
    case (state_q)
      S_IDLE: if (start) begin
        ox_d    = old_x;
        oy_d    = old_y;
        nx_d    = new_x;
        ny_d    = new_y;
        valid_d = 1'b0;
        code_d  = C_OK;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        src_col_d = src_cell[PIECE_W-1];
        sx_d      = sgn(dx);
        sy_d      = sgn(dy);
        // old == new gives dx = dy = 0, which neither ortho nor diag accepts
        if (!legal || src_cell == '0) begin
          code_d  = C_GEOM;
          state_d = S_DONE;
        end else begin
          cx_d    = $signed({1'b0, ox_q}) + sgn(dx);
          cy_d    = $signed({1'b0, oy_q}) + sgn(dy);
          state_d = S_WALK;
        end
      end
      S_WALK: begin
        if (at_dst) begin
          if (cur_cell == '0 || cur_cell[PIECE_W-1] != src_col_q) begin
            valid_d = 1'b1;
            code_d  = C_OK;
          end else begin
            code_d  = C_OWN;
          end
          state_d = S_DONE;
        end else if (cur_cell != '0) begin
          code_d  = C_BLOCK;
          state_d = S_DONE;
        end else begin
          cx_d = cx_q + sx_q;
          cy_d = cy_q + sy_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ox_q      <= '0;
      oy_q      <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      src_col_q <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= C_OK;
    end else begin
      state_q   <= state_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      src_col_q <= src_col_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign move_valid = valid_q;
  assign fail_code  = code_q;

endmodule

// File: tb/tb_check_slider.sv
// Directed bench for check_slider: queen, rook, bishop and a 4x4 queen instance.
module tb_check_slider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [3:0] start_v;
  logic [2:0] ox, oy, nx, ny;
  logic [7:0][7:0][3:0] board8;
  logic [3:0][3:0][3:0] board4;
  logic [3:0] busy_w, done_w, valid_w;
  logic [1:0] code_w [4];

  int checks = 0;
  int failures = 0;

  check_slider #(.MODE(2)) u_q (
    .CLOCK_50(clk), .reset(reset), .start(start_v[0]),
    .old_x(ox), .old_y(oy), .new_x(nx), .new_y(ny), .board_in(board8),
    .busy(busy_w[0]), .done(done_w[0]), .move_valid(valid_w[0]), .fail_code(code_w[0]));

  check_slider #(.MODE(0)) u_r (
    .CLOCK_50(clk), .reset(reset), .start(start_v[1]),
    .old_x(ox), .old_y(oy), .new_x(nx), .new_y(ny), .board_in(board8),
    .busy(busy_w[1]), .done(done_w[1]), .move_valid(valid_w[1]), .fail_code(code_w[1]));

  check_slider #(.MODE(1)) u_b (
    .CLOCK_50(clk), .reset(reset), .start(start_v[2]),
    .old_x(ox), .old_y(oy), .new_x(nx), .new_y(ny), .board_in(board8),
    .busy(busy_w[2]), .done(done_w[2]), .move_valid(valid_w[2]), .fail_code(code_w[2]));

  check_slider #(.BOARD_N(4), .COORD_W(2), .MODE(2)) u_s (
    .CLOCK_50(clk), .reset(reset), .start(start_v[3]),
    .old_x(ox[1:0]), .old_y(oy[1:0]), .new_x(nx[1:0]), .new_y(ny[1:0]), .board_in(board4),
    .busy(busy_w[3]), .done(done_w[3]), .move_valid(valid_w[3]), .fail_code(code_w[3]));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start on instance w; lat = cycles from accept to done (-1 if none in budget).
  task automatic run(input int w, input int x0, input int y0, input int x1, input int y1,
                     output int lat);
    @(negedge clk);
    ox = 3'(x0); oy = 3'(y0); nx = 3'(x1); ny = 3'(y1);
    start_v[w] = 1'b1;
    @(posedge clk);
    #1 start_v[w] = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done_w[w]) begin
        lat = n;
        break;
      end
    end
  endtask

  int lat, dcount, first;

  initial begin
    reset = 1'b1;
    start_v = '0;
    ox = '0; oy = '0; nx = '0; ny = '0;
    board8 = '0;
    board4 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  busy_w[0],  0);
    chk("rst_done",  done_w[0],  0);
    chk("rst_valid", valid_w[0], 0);
    chk("rst_code",  code_w[0],  0);
    reset = 1'b0;

    // 1: clear file move
    board8[0][0] = 4'h1;
    run(0, 0, 0, 0, 7, lat);
    chk("t1_lat", lat, 9);
    chk("t1_valid", valid_w[0], 1);
    chk("t1_code", code_w[0], 0);

    // 2: blocked diagonal
    board8 = '0;
    board8[3][3] = 4'h1;
    board8[5][5] = 4'h9;
    run(0, 3, 3, 7, 7, lat);
    chk("t2_lat", lat, 4);
    chk("t2_valid", valid_w[0], 0);
    chk("t2_code", code_w[0], 2);

    // 3: capture of opposite colour, then own piece
    run(0, 3, 3, 5, 5, lat);
    chk("t3_lat", lat, 4);
    chk("t3_valid", valid_w[0], 1);
    chk("t3_code", code_w[0], 0);
    board8[5][5] = 4'h2;
    run(0, 3, 3, 5, 5, lat);
    chk("t3o_lat", lat, 4);
    chk("t3o_valid", valid_w[0], 0);
    chk("t3o_code", code_w[0], 3);

    // 4: bad geometry cases
    board8 = '0;
    board8[2][2] = 4'h1;
    board8[1][1] = 4'h1;
    run(1, 2, 2, 4, 4, lat);
    chk("t4r_lat", lat, 2);
    chk("t4r_valid", valid_w[1], 0);
    chk("t4r_code", code_w[1], 1);
    run(2, 2, 2, 2, 6, lat);
    chk("t4b_lat", lat, 2);
    chk("t4b_code", code_w[2], 1);
    run(0, 1, 1, 1, 1, lat);
    chk("t4s_lat", lat, 2);
    chk("t4s_code", code_w[0], 1);
    run(0, 6, 6, 6, 7, lat);
    chk("t4e_lat", lat, 2);
    chk("t4e_valid", valid_w[0], 0);
    chk("t4e_code", code_w[0], 1);
    board8[4][4] = 4'hA;
    run(2, 2, 2, 4, 4, lat);
    chk("t4bd_lat", lat, 4);
    chk("t4bd_valid", valid_w[2], 1);

    // 5: start re-pulsed in WALK and DONE is ignored; cycle after done is accepted
    board8 = '0;
    board8[0][0] = 4'h1;
    @(negedge clk);
    ox = 3'd0; oy = 3'd0; nx = 3'd0; ny = 3'd7;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    dcount = 0;
    first = -1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (done_w[0]) begin
        dcount++;
        if (first < 0) first = n;
      end
      if (n == 10) chk("t5_held", valid_w[0], 1);
      if (n == 11) begin
        chk("t5_acc_busy", busy_w[0], 1);
        chk("t5_acc_clr", valid_w[0], 0);
      end
      start_v[0] = (n == 3 || n == 9 || n == 10);
    end
    chk("t5_ndone", dcount, 1);
    chk("t5_first", first, 9);
    lat = -1;
    for (int n = 12; n <= 40; n++) begin
      @(negedge clk);
      if (done_w[0]) begin
        lat = n;
        break;
      end
    end
    chk("t5_lat2", lat, 19);
    chk("t5_valid2", valid_w[0], 1);

    // 6: reset mid-walk abandons the request
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_walk_busy", busy_w[0], 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_busy", busy_w[0], 0);
    chk("t6_done", done_w[0], 0);
    chk("t6_valid", valid_w[0], 0);
    chk("t6_code", code_w[0], 0);
    reset = 1'b0;
    dcount = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done_w[0]) dcount++;
    end
    chk("t6_nodone", dcount, 0);

    // 6b: 4x4 board instance
    board4[0][0] = 4'h1;
    run(3, 0, 0, 0, 3, lat);
    chk("t6s_lat", lat, 5);
    chk("t6s_valid", valid_w[3], 1);
    chk("t6s_code", code_w[3], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
